// File: rtl/count_checker_pkg.sv
// -----------------------------------------------------------------------------
// count_checker_pkg
//   Shared definitions for the count_checker block: FSM state encoding and
//   the width of the wrap event counter.
// -----------------------------------------------------------------------------
package count_checker_pkg;

  // Checker FSM states. IDLE waits for the first sample, TRACK follows the
  // stream, FAIL parks after a mismatch until clear or reset.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAIL  = 2'd2
  } state_t;

  // Width of the all-ones-to-zero wrap counter (rolls over modulo 2^16).
  localparam int WRAP_W = 16;

endpackage : count_checker_pkg

// File: rtl/count_checker_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of rolling over. A synchronous
//   clear takes priority over an increment in the same cycle.
//
// Ports
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset (count -> 0)
//   inc      : add one this cycle unless already saturated
//   clr      : synchronous clear to 0
//   count    : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == {WIDTH{1'b1}});

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule : sat_counter

// File: rtl/count_checker.sv
// -----------------------------------------------------------------------------
// count_checker
//   Watches a free-running counter stream and checks that each valid sample
//   is the previous one plus one (mod 2^WIDTH). Reports mismatches, source
//   restarts (a jump back to 0) and matched all-ones-to-zero wraps. All
//   outputs are registered: the response to a sample appears the cycle after
//   the edge on which it was taken.
//
// Configuration
//   COUNT_CHECKER_RESYNC_EN : when defined, a mismatch re-locks onto the new
//                             value and stays in TRACK; otherwise a mismatch
//                             parks the checker in FAIL until clear/reset.
//
// Ports
//   clk           : clock, rising edge
//   reset_n       : asynchronous active-low reset
//   value         : observed count sample
//   valid         : value is sampled on this edge when high
//   clear         : synchronous return to IDLE, clears counters; beats valid
//   locked        : checker is in TRACK
//   expected      : next value predicted
//   err_pulse     : one-cycle flag, sequence mismatch
//   restart_pulse : one-cycle flag, source restarted at 0
//   err_count     : mismatches since reset/clear, saturating
//   wrap_count    : matched all-ones-to-zero wraps, modulo 2^16
// -----------------------------------------------------------------------------
module count_checker
  import count_checker_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  value,
  input  logic              valid,
  input  logic              clear,
  output logic              locked,
  output logic [WIDTH-1:0]  expected,
  output logic              err_pulse,
  output logic              restart_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count
);

`ifdef COUNT_CHECKER_RESYNC_EN
  localparam bit RESYNC_EN = 1'b1;
`else
  localparam bit RESYNC_EN = 1'b0;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_locked;
  logic [WIDTH-1:0]  r_expected;
  logic [WIDTH-1:0]  w_expected_nxt;
  logic              r_err_pulse;
  logic              w_err_pulse_nxt;
  logic              r_restart_pulse;
  logic              w_restart_pulse_nxt;
  logic [WRAP_W-1:0] r_wrap_count;
  logic [WRAP_W-1:0] w_wrap_count_nxt;
  logic              w_err_inc;

  logic              w_match;
  logic              w_value_zero;
  logic              w_expected_max;
  logic              w_mismatch;

  assign w_match        = (value == r_expected);
  assign w_value_zero   = (value == '0);
  assign w_expected_max = (r_expected == {WIDTH{1'b1}});
  // A real error: off-sequence and not a restart at zero.
  assign w_mismatch     = (r_state == TRACK) && valid && !clear &&
                          !w_match && !w_value_zero;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_locked <= (w_state_nxt == TRACK);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default first;
  // otherwise a path that skips it infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else if (valid) begin
      unique case (r_state)
        IDLE:    w_state_nxt = TRACK;
        TRACK:   if (w_mismatch && !RESYNC_EN) w_state_nxt = FAIL;
        FAIL:    w_state_nxt = FAIL;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    w_expected_nxt      = r_expected;
    w_err_pulse_nxt     = 1'b0;
    w_restart_pulse_nxt = 1'b0;
    w_wrap_count_nxt    = r_wrap_count;
    w_err_inc           = 1'b0;

    if (clear) begin
      w_expected_nxt   = '0;
      w_wrap_count_nxt = '0;
    end else if (valid) begin
      unique case (r_state)
        IDLE: begin
          w_expected_nxt = value + 1'b1;
        end
        TRACK: begin
          if (w_match) begin
            w_expected_nxt = r_expected + 1'b1;
            if (w_expected_max) begin
              w_wrap_count_nxt = r_wrap_count + 1'b1;
            end
          end else if (w_value_zero) begin
            // Source restarted: resume from 0 without flagging an error.
            w_restart_pulse_nxt = 1'b1;
            w_expected_nxt      = WIDTH'(1);
          end else begin
            w_err_pulse_nxt = 1'b1;
            w_err_inc       = 1'b1;
            // In FAIL the prediction is frozen; with resync we re-lock.
            if (RESYNC_EN) begin
              w_expected_nxt = value + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_expected      <= '0;
      r_err_pulse     <= 1'b0;
      r_restart_pulse <= 1'b0;
      r_wrap_count    <= '0;
    end else begin
      r_expected      <= w_expected_nxt;
      r_err_pulse     <= w_err_pulse_nxt;
      r_restart_pulse <= w_restart_pulse_nxt;
      r_wrap_count    <= w_wrap_count_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating error counter
  // ---------------------------------------------------------------------------
  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_err_inc),
    .clr     (clear),
    .count   (err_count)
  );

  assign locked        = r_locked;
  assign expected      = r_expected;
  assign err_pulse     = r_err_pulse;
  assign restart_pulse = r_restart_pulse;
  assign wrap_count    = r_wrap_count;

endmodule : count_checker

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of the observed count stream.
REQ-002 SHALL have parameter ERR_W, default 8, width of the saturating error counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port value  input  WIDTH  observed count sample.
REQ-006 SHALL have port valid  input  1  value is sampled on this edge when high.
REQ-007 SHALL have port clear  input  1  synchronous return to IDLE; clears all counters.
REQ-008 SHALL have port locked  output  1  checker is in TRACK.
REQ-009 SHALL have port expected  output  WIDTH  next value predicted.
REQ-010 SHALL have port err_pulse  output  1  one-cycle flag: sequence mismatch.
REQ-011 SHALL have port restart_pulse  output  1  one-cycle flag: source restarted at 0.
REQ-012 SHALL have port err_count  output  ERR_W  mismatches since reset/clear, saturating.
REQ-013 SHALL have port wrap_count  output  16  matched all-ones-to-zero wraps, modulo 2^16.

Function
REQ-014 SHALL implement states IDLE, TRACK, FAIL; all outputs registered; response appears the cycle after the sampled edge.
REQ-015 SHALL ignore value when valid=0: state, expected and counters hold, and pulses are 0.
REQ-016 IDLE + valid: SHALL set expected=value+1 mod 2^WIDTH, go TRACK, with no error.
REQ-017 TRACK + valid + value==expected: SHALL set expected=expected+1 mod 2^WIDTH.
REQ-018 TRACK + valid + value==expected==all-ones: SHALL also increment wrap_count, wrapping 0xFFFF->0.
REQ-019 TRACK + valid + value!=expected + value==0: SHALL pulse restart_pulse, set expected=1, and not count an error.
REQ-020 TRACK + valid + value!=expected + value!=0: SHALL pulse err_pulse and increment err_count, holding at all-ones.
REQ-021 Resulting state after REQ-020 SHALL be governed by REQ-027/REQ-028.
REQ-022 FAIL: SHALL ignore samples, hold locked=0, and hold counters.
REQ-023 clear=1 in any state SHALL give IDLE, expected=0, zero counters and pulses next cycle.
REQ-024 clear SHALL take priority over a simultaneous valid sample, which is discarded.
REQ-025 locked SHALL be 1 exactly when state is TRACK.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, locked=0, expected=0, err_pulse=0, restart_pulse=0, err_count=0, wrap_count=0, including mid-TRACK; first valid after release follows REQ-016.

Configuration
REQ-027 With COUNT_CHECKER_RESYNC_EN defined, a mismatch (REQ-020) SHALL stay in TRACK with expected=value+1.
REQ-028 Without COUNT_CHECKER_RESYNC_EN, a mismatch SHALL move to FAIL; only clear or reset_n leaves FAIL.

Structure
REQ-029 Shared package count_checker_pkg SHALL hold the state encoding (IDLE=2'd0, TRACK=2'd1, FAIL=2'd2) and the wrap_count width constant 16.
REQ-030 Saturating error counter SHALL be sub-module sat_counter (parameter width; inputs inc and clr).

Verification
REQ-031 Counter source reset at t=17, ramp 0..5 -> locked after first sample, expected=6, err_count=0.
REQ-032 Ramp 0xFD..0x02 (WIDTH=8) -> wrap_count=1, no err_pulse.
REQ-033 Sequence 3,4,9,10 with RESYNC_EN -> one err_pulse at 9, err_count=1, expected=11, locked=1.
REQ-034 Same sequence without RESYNC_EN -> err_count=1, locked=0 after 9; 10 is ignored; clear -> IDLE, err_count=0.
REQ-035 Sequence 7,8,0,1 -> restart_pulse at 0, err_count=0, expected=2.
REQ-036 reset_n low mid-ramp, asynchronous between edges -> outputs zero before next edge; clear together with valid -> sample discarded.
